// File: rtl/wg_dealloc_arbiter.sv
// rtl/wg_dealloc_arbiter.sv - round-robin arbiter offering CU workgroup deallocations to the dispatcher
//
// Collects per-CU deallocation requests and presents one at a time to the
// dispatcher. The offer is held stable until accepted, then the winning CU is
// acknowledged with a one-cycle pulse. The rr pointer moves past the winner on
// every accept, so every requesting CU is served once per NUMBER_CU grants.
//
// Optional feature macro: DEALLOC_ARBITER_STALL_CNT_EN
//   When defined, builds a saturating 32-bit counter of offer cycles that
//   did not see an accept, exported on dealloc_arbiter_stall_cnt.
//
// Ports:
//   clk                             clock, rising edge
//   rst_n                           asynchronous active-low reset
//   cu_dealloc_req                  per-CU request level, held until ack
//   cu_dealloc_wgid                 per-CU wgid, CU i at [i*WG_ID_WIDTH +: WG_ID_WIDTH]
//   cu_dealloc_ack                  one-hot one-cycle ack of the consumed request
//   dis_controller_wg_dealloc_valid dispatcher accept pulse for the current offer
//   dealloc_arbiter_available       offer valid
//   dealloc_arbiter_cu_id           CU of the current offer
//   dealloc_arbiter_wgid            wgid of the current offer
//   dealloc_arbiter_stall_cnt       stall counter (only with the macro)

module wg_dealloc_arbiter #(
    parameter int NUMBER_CU   = 64,
    parameter int CU_ID_WIDTH = 6,
    parameter int WG_ID_WIDTH = 6
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUMBER_CU-1:0]             cu_dealloc_req,
    input  logic [NUMBER_CU*WG_ID_WIDTH-1:0] cu_dealloc_wgid,
    output logic [NUMBER_CU-1:0]             cu_dealloc_ack,
    input  logic                             dis_controller_wg_dealloc_valid,
    output logic                             dealloc_arbiter_available,
    output logic [CU_ID_WIDTH-1:0]           dealloc_arbiter_cu_id,
    output logic [WG_ID_WIDTH-1:0]           dealloc_arbiter_wgid
`ifdef DEALLOC_ARBITER_STALL_CNT_EN
    ,
    output logic [31:0]                      dealloc_arbiter_stall_cnt
`endif
);

    localparam int CW1 = CU_ID_WIDTH + 1;
    // NUMBER_CU at one bit wider than a CU index so it is representable.
    localparam logic [CU_ID_WIDTH:0]   NCU_W   = CW1'(NUMBER_CU);
    localparam logic [CU_ID_WIDTH-1:0] LAST_CU = CU_ID_WIDTH'(NUMBER_CU - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CU_ID_WIDTH-1:0] ptr_q, ptr_d;
    logic [CU_ID_WIDTH-1:0] cu_id_q, cu_id_d;
    logic [WG_ID_WIDTH-1:0] wgid_q, wgid_d;
    logic                   avail_q, avail_d;
    logic [NUMBER_CU-1:0]   ack_q, ack_d;

    logic                   grant_found;
    logic [CU_ID_WIDTH-1:0] grant_idx;
    logic [CU_ID_WIDTH:0]   cand;

    // Unpack the flat wgid bus so it can be indexed by the winning CU.
    logic [WG_ID_WIDTH-1:0] wgid_arr [NUMBER_CU];

    for (genvar gi = 0; gi < NUMBER_CU; gi++) begin : g_wgid_unpack
        assign wgid_arr[gi] = cu_dealloc_wgid[gi*WG_ID_WIDTH +: WG_ID_WIDTH];
    end

    // Round-robin search: walk offsets 0..NUMBER_CU-1 from the pointer,
    // folding back past NUMBER_CU-1 (which need not be a power of two),
    // and keep the first requesting CU encountered.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUMBER_CU; i++) begin
            cand = {1'b0, ptr_q} + CW1'(i);
            if (cand >= NCU_W) begin
                cand = cand - NCU_W;
            end
            if (!grant_found && cu_dealloc_req[cand[CU_ID_WIDTH-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[CU_ID_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cu_id_d = cu_id_q;
        wgid_d  = wgid_q;
        avail_d = avail_q;
        ack_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    cu_id_d = grant_idx;
                    wgid_d  = wgid_arr[grant_idx];
                    avail_d = 1'b1;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                // Offer is frozen here; only the accept moves things on.
                if (dis_controller_wg_dealloc_valid) begin
                    avail_d        = 1'b0;
                    ack_d[cu_id_q] = 1'b1;
                    ptr_d          = (cu_id_q == LAST_CU) ? '0
                                                          : cu_id_q + CU_ID_WIDTH'(1);
                    state_d        = ST_ACK;
                end
            end
            ST_ACK: begin
                // Gives the acked CU a cycle to drop its request before
                // the next search.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cu_id_q <= '0;
            wgid_q  <= '0;
            avail_q <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cu_id_q <= cu_id_d;
            wgid_q  <= wgid_d;
            avail_q <= avail_d;
            ack_q   <= ack_d;
        end
    end

    assign cu_dealloc_ack            = ack_q;
    assign dealloc_arbiter_available = avail_q;
    assign dealloc_arbiter_cu_id     = cu_id_q;
    assign dealloc_arbiter_wgid      = wgid_q;

`ifdef DEALLOC_ARBITER_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == ST_OFFER && !dis_controller_wg_dealloc_valid && stall_q != 32'hFFFF_FFFF) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign dealloc_arbiter_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_wg_dealloc_arbiter.sv
// tb/tb_wg_dealloc_arbiter.sv - directed self-checking bench for wg_dealloc_arbiter

module tb_wg_dealloc_arbiter;

    localparam int N  = 64;
    localparam int CW = 6;
    localparam int WW = 6;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*WW-1:0] wgid;
    logic [N-1:0]    ack;
    logic            valid;
    logic            avail;
    logic [CW-1:0]   cu_id;
    logic [WW-1:0]   wg_out;
`ifdef DEALLOC_ARBITER_STALL_CNT_EN
    logic [31:0]     stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wg_dealloc_arbiter #(
        .NUMBER_CU  (N),
        .CU_ID_WIDTH(CW),
        .WG_ID_WIDTH(WW)
    ) dut (
        .clk                            (clk),
        .rst_n                          (rst_n),
        .cu_dealloc_req                 (req),
        .cu_dealloc_wgid                (wgid),
        .cu_dealloc_ack                 (ack),
        .dis_controller_wg_dealloc_valid(valid),
        .dealloc_arbiter_available      (avail),
        .dealloc_arbiter_cu_id          (cu_id),
        .dealloc_arbiter_wgid           (wg_out)
`ifdef DEALLOC_ARBITER_STALL_CNT_EN
        ,
        .dealloc_arbiter_stall_cnt      (stall_cnt)
`endif
    );

    function automatic logic [WW-1:0] wg_of(input int cu);
        return WW'(cu * 7 + 3);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int cu, input logic on);
        req[cu] = on;
        wgid[cu*WW +: WW] = wg_of(cu);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        wgid  = '0;
        valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_offer(input string name, input int max_cycles);
        int n;
        n = 0;
        while (!avail && n < max_cycles) begin
            tick();
            n++;
        end
        checks++;
        if (avail !== 1'b1) begin
            failures++;
            $display("FAIL %s offer_timeout avail=%0b required=1", name, avail);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (avail !== 1'b0 || cu_id !== '0 || wg_out !== '0 || ack !== '0) begin
            failures++;
            $display("FAIL reset_values avail=%0b cu_id=%0d wgid=%0h ack=%0h required 0/0/0/0",
                     avail, cu_id, wg_out, ack);
        end
`ifdef DEALLOC_ARBITER_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_stall stall=%0d required=0", stall_cnt);
        end
`endif
        // Accept pulse while idle must be ignored.
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        checks++;
        if (ack !== '0 || avail !== 1'b0) begin
            failures++;
            $display("FAIL idle_valid_ignored ack=%0h avail=%0b required 0/0", ack, avail);
        end
    endtask

    task automatic test_single();
        logic [N-1:0] oh;
        do_reset();
        set_req(5, 1'b1);
        tick();
        checks++;
        if (avail !== 1'b1 || cu_id !== CW'(5) || wg_out !== wg_of(5)) begin
            failures++;
            $display("FAIL single_offer avail=%0b cu_id=%0d wgid=%0h required 1/5/%0h",
                     avail, cu_id, wg_out, wg_of(5));
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (avail !== 1'b1 || cu_id !== CW'(5) || ack !== '0) begin
                failures++;
                $display("FAIL single_hold avail=%0b cu_id=%0d ack=%0h required 1/5/0",
                         avail, cu_id, ack);
            end
        end
        valid = 1'b1;
        tick();
        valid = 1'b0;
        oh = '0;
        oh[5] = 1'b1;
        checks++;
        if (ack !== oh || avail !== 1'b0) begin
            failures++;
            $display("FAIL single_ack ack=%0h avail=%0b required %0h/0", ack, avail, oh);
        end
`ifdef DEALLOC_ARBITER_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 32'd3) begin
            failures++;
            $display("FAIL single_stall stall=%0d required=3", stall_cnt);
        end
`endif
        set_req(5, 1'b0);
        tick();
        checks++;
        if (ack !== '0) begin
            failures++;
            $display("FAIL single_ack_width ack=%0h required=0", ack);
        end
    endtask

    task automatic test_fairness();
        int exp_seq [6] = '{0, 3, 63, 0, 3, 63};
        logic [N-1:0] oh;
        do_reset();
        set_req(0, 1'b1);
        set_req(3, 1'b1);
        set_req(63, 1'b1);
        for (int k = 0; k < 6; k++) begin
            wait_offer("fair", 10);
            checks++;
            if (cu_id !== CW'(exp_seq[k]) || wg_out !== wg_of(exp_seq[k])) begin
                failures++;
                $display("FAIL fair_order grant=%0d cu_id=%0d wgid=%0h required %0d/%0h",
                         k, cu_id, wg_out, exp_seq[k], wg_of(exp_seq[k]));
            end
            valid = 1'b1;
            tick();
            valid = 1'b0;
            oh = '0;
            oh[exp_seq[k]] = 1'b1;
            checks++;
            if (ack !== oh) begin
                failures++;
                $display("FAIL fair_ack grant=%0d ack=%0h required=%0h", k, ack, oh);
            end
            tick();
            checks++;
            if (ack !== '0 || avail !== 1'b0) begin
                failures++;
                $display("FAIL fair_ack_pulse grant=%0d ack=%0h avail=%0b required 0/0", k, ack, avail);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        set_req(62, 1'b1);
        wait_offer("wrap_prep", 10);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        set_req(62, 1'b0);
        set_req(0, 1'b1);
        set_req(63, 1'b1);
        wait_offer("wrap_first", 10);
        checks++;
        if (cu_id !== CW'(63)) begin
            failures++;
            $display("FAIL wrap_first cu_id=%0d required=63", cu_id);
        end
        valid = 1'b1;
        tick();
        valid = 1'b0;
        set_req(63, 1'b0);
        wait_offer("wrap_second", 10);
        checks++;
        if (cu_id !== CW'(0)) begin
            failures++;
            $display("FAIL wrap_second cu_id=%0d required=0", cu_id);
        end
        valid = 1'b1;
        tick();
        valid = 1'b0;
        set_req(0, 1'b0);
        tick();
    endtask

    task automatic test_held_offer();
        int bad;
        do_reset();
        set_req(7, 1'b1);
        tick();
        set_req(2, 1'b1);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (avail !== 1'b1 || cu_id !== CW'(7) || wg_out !== wg_of(7)) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL held_offer bad_cycles=%0d required=0", bad);
        end
        valid = 1'b1;
        tick();
        valid = 1'b0;
        set_req(7, 1'b0);
        tick();
        checks++;
        if (avail !== 1'b0) begin
            failures++;
            $display("FAIL held_gap avail=%0b required=0", avail);
        end
        tick();
        checks++;
        if (avail !== 1'b1 || cu_id !== CW'(2) || wg_out !== wg_of(2)) begin
            failures++;
            $display("FAIL held_next avail=%0b cu_id=%0d wgid=%0h required 1/2/%0h",
                     avail, cu_id, wg_out, wg_of(2));
        end
        valid = 1'b1;
        tick();
        valid = 1'b0;
        set_req(2, 1'b0);
        tick();
    endtask

    task automatic test_reset_mid_offer();
        do_reset();
        set_req(9, 1'b1);
        tick();
        checks++;
        if (avail !== 1'b1 || cu_id !== CW'(9)) begin
            failures++;
            $display("FAIL rmo_offer avail=%0b cu_id=%0d required 1/9", avail, cu_id);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (avail !== 1'b0 || ack !== '0 || cu_id !== '0) begin
            failures++;
            $display("FAIL rmo_async avail=%0b ack=%0h cu_id=%0d required 0/0/0", avail, ack, cu_id);
        end
        tick();
        checks++;
        if (ack !== '0 || avail !== 1'b0) begin
            failures++;
            $display("FAIL rmo_no_ack ack=%0h avail=%0b required 0/0", ack, avail);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (avail !== 1'b1 || cu_id !== CW'(9) || wg_out !== wg_of(9)) begin
            failures++;
            $display("FAIL rmo_reoffer avail=%0b cu_id=%0d wgid=%0h required 1/9/%0h",
                     avail, cu_id, wg_out, wg_of(9));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        wgid  = '0;
        valid = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_held_offer();
        test_reset_mid_offer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wg_dealloc_arbiter.md
# wg_dealloc_arbiter

Round-robin arbiter that collects workgroup-deallocation requests from all compute units and offers them one at a time to the dispatcher controller's deallocation port. It sits between the per-CU wavefront-done logic and the dispatcher. It holds each offer stable until the dispatcher accepts it, then acknowledges the winning CU. Fairness is guaranteed across CUs regardless of request pattern.

## Interface
- NUMBER_CU, 64, number of compute units / requesters (need not be a power of 2)
- CU_ID_WIDTH, 6, width of a CU index; 2**CU_ID_WIDTH >= NUMBER_CU
- WG_ID_WIDTH, 6, width of a workgroup id
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- cu_dealloc_req  input  NUMBER_CU  per-CU request level; held high with stable wgid until matching ack
- cu_dealloc_wgid  input  NUMBER_CU*WG_ID_WIDTH  per-CU wgid, CU i in bits [i*WG_ID_WIDTH +: WG_ID_WIDTH]
- cu_dealloc_ack  output  NUMBER_CU  one-hot, one-cycle pulse: request of that CU consumed
- dis_controller_wg_dealloc_valid  input  1  dispatcher accepted the current offer (one-cycle pulse)
- dealloc_arbiter_available  output  1  offer valid
- dealloc_arbiter_cu_id  output  CU_ID_WIDTH  CU of current offer
- dealloc_arbiter_wgid  output  WG_ID_WIDTH  wgid of current offer
- dealloc_arbiter_stall_cnt  output  32  present only with DEALLOC_ARBITER_STALL_CNT_EN

## Operation
- Reset values: available 0, cu_id 0, wgid 0, cu_dealloc_ack all 0, rr pointer 0, state ST_IDLE, stall_cnt 0.
- Rr pointer: CU index with highest priority; search order ptr, ptr+1, …, NUMBER_CU-1, 0, …, ptr-1.
- ST_IDLE: if any cu_dealloc_req bit is set, select the first set bit in search order. Register its cu_id and wgid, set available=1, and go to ST_OFFER. Otherwise stay.
- ST_OFFER: available, cu_id and wgid are held constant.
  - On dis_controller_wg_dealloc_valid=1: clear available and pulse cu_dealloc_ack[cu_id].
  - Also set ptr <= cu_id+1, wrapping to 0 when cu_id == NUMBER_CU-1.
  - Go to ST_ACK.
- ST_ACK: single cycle so the CU can drop its request. Go to ST_IDLE. Requests are not sampled here.
- Requests arriving or dropping during ST_OFFER do not change the offer. A CU that drops its request before ack violates protocol; the arbiter still completes the offer unchanged.
- dis_controller_wg_dealloc_valid outside ST_OFFER is ignored.
- Outputs other than the stall counter are registered; no combinational path from inputs to outputs.

## Timing
- Request seen high in cycle c while in ST_IDLE → available=1 in cycle c+1.
- Accept pulse in cycle k (ST_OFFER) → available=0 and ack pulse in cycle k+1 → ST_IDLE in k+2.
- Earliest next offer is cycle k+3, giving a throughput of 1 grant per 3 cycles minimum.
- The dispatcher may take any number of cycles to accept. The offer is held indefinitely; there is no timeout.
- Simultaneous requests from all CUs: each CU is granted exactly once per NUMBER_CU grants.
- Reset asserted mid-offer: all state clears immediately (asynchronous). No ack is issued for the abandoned offer; the CU keeps requesting and is re-offered after reset.

## Configuration
- DEALLOC_ARBITER_STALL_CNT_EN defined:
  - dealloc_arbiter_stall_cnt port and a 32-bit counter are built.
  - The counter increments on every cycle in ST_OFFER without an accept, and saturates at 0xFFFFFFFF.
  - Reset to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Single request: CU 5 requests with wgid 0x2A in cycle 10 → available=1, cu_id=5, wgid=0x2A in cycle 11. Accept in cycle 14 → cu_dealloc_ack[5] pulse in cycle 15, available=0 in cycle 15. With the macro, stall_cnt=3.
- Fairness: CUs 0, 3 and 63 request continuously and accept fires one cycle after every offer → grant order 0, 3, 63, 0, 3, 63. Each ack is one-hot and one cycle wide.
- Wrap: ptr=63 after a grant to CU 62, with CUs 0 and 63 requesting → CU 63 granted, then CU 0.
- Held offer: CU 7 is offered and CU 2 requests during the offer; accept comes 50 cycles later → cu_id stays 7 for all 50 cycles. CU 2 is offered 3 cycles after the accept.
- Reset mid-offer: rst_n low during ST_OFFER for CU 9 → available, ack and ptr read 0 immediately. After release, with CU 9 still requesting, CU 9 is re-offered 1 cycle later.
